// File: rtl/call_stack_controller.sv
// Sequences the hardware return-address stack for CALL/RET. It turns single-cycle
// requests into timed push/pop strobes, captures the popped address, and tracks
// depth with sticky overflow/underflow flags. The stack has no reset, so after
// reset this block pops it until it reports empty.
module call_stack_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_MAX  = 31,
  parameter int unsigned PTR_WIDTH  = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  call_req,
  input  logic [DATA_WIDTH-1:0] call_addr,
  input  logic                  ret_req,
  input  logic                  err_clear,
  output logic                  busy,
  output logic                  call_done,
  output logic                  ret_valid,
  output logic [DATA_WIDTH-1:0] ret_addr,
  output logic [PTR_WIDTH-1:0]  depth,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  input  logic                  stk_full,
  input  logic                  stk_empty
);

  typedef enum logic [2:0] {
    StDrain,
    StIdle,
    StPush,
    StPop,
    StCapture
  } state_e;

  state_e                r_state;
  logic [PTR_WIDTH-1:0]  r_depth;
  logic [DATA_WIDTH-1:0] r_call_addr;
  logic [DATA_WIDTH-1:0] r_ret_addr;
  logic                  r_call_done;
  logic                  r_ret_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  state_e                w_state_next;
  logic [PTR_WIDTH-1:0]  w_depth_next;
  logic [DATA_WIDTH-1:0] w_call_addr_next;
  logic [DATA_WIDTH-1:0] w_ret_addr_next;
  logic                  w_call_done_next;
  logic                  w_ret_valid_next;
  logic                  w_overflow_next;
  logic                  w_underflow_next;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;

  // Either the local count or the stack itself may report a boundary.
  assign w_full  = (r_depth == PTR_WIDTH'(DEPTH_MAX)) || stk_full;
  assign w_empty = (r_depth == '0) || stk_empty;

  // Next-state, strobe decode and result/flag updates.
  always_comb begin
    w_state_next     = r_state;
    w_depth_next     = r_depth;
    w_call_addr_next = r_call_addr;
    w_ret_addr_next  = r_ret_addr;
    w_call_done_next = 1'b0;
    w_ret_valid_next = 1'b0;
    // Clear first so that a new error in the same cycle wins.
    w_overflow_next  = r_overflow & ~err_clear;
    w_underflow_next = r_underflow & ~err_clear;
    w_push           = 1'b0;
    w_pop            = 1'b0;
    unique case (r_state)
      StDrain: begin
        w_pop = ~stk_empty;
        if (stk_empty) begin
          w_state_next = StIdle;
        end
      end
      StIdle: begin
        if (call_req) begin
          if (w_full) begin
            w_overflow_next  = 1'b1;
            w_call_done_next = 1'b1;
          end else begin
            w_call_addr_next = call_addr;
            w_state_next     = StPush;
          end
        end else if (ret_req) begin
          if (w_empty) begin
            w_underflow_next = 1'b1;
            w_ret_addr_next  = '0;
            w_ret_valid_next = 1'b1;
          end else begin
            w_state_next = StPop;
          end
        end
      end
      StPush: begin
        w_push           = 1'b1;
        w_depth_next     = r_depth + PTR_WIDTH'(1);
        w_call_done_next = 1'b1;
        w_state_next     = StIdle;
      end
      StPop: begin
        w_pop        = 1'b1;
        w_depth_next = r_depth - PTR_WIDTH'(1);
        w_state_next = StCapture;
      end
      StCapture: begin
        // The stack presents the popped entry on the edge that ended StPop.
        w_ret_addr_next  = stk_data_out;
        w_ret_valid_next = 1'b1;
        w_state_next     = StIdle;
      end
      default: begin
        w_state_next = StDrain;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StDrain;
      r_depth     <= '0;
      r_call_addr <= '0;
      r_ret_addr  <= '0;
      r_call_done <= 1'b0;
      r_ret_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_depth     <= w_depth_next;
      r_call_addr <= w_call_addr_next;
      r_ret_addr  <= w_ret_addr_next;
      r_call_done <= w_call_done_next;
      r_ret_valid <= w_ret_valid_next;
      r_overflow  <= w_overflow_next;
      r_underflow <= w_underflow_next;
    end
  end

  // Strobes are gated by reset so an in-flight push/pop aborts at once.
  assign stk_push      = w_push & ~reset;
  assign stk_pop       = w_pop & ~reset;
  assign stk_data_in   = r_call_addr;
  assign busy          = (r_state != StIdle);
  assign call_done     = r_call_done;
  assign ret_valid     = r_ret_valid;
  assign ret_addr      = r_ret_addr;
  assign depth         = r_depth;
  assign overflow_err  = r_overflow;
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_call_stack_controller.sv
// Directed bench for call_stack_controller with a behavioural 32x32 stack model.
module tb_call_stack_controller;

  logic        clock;
  logic        reset;
  logic        call_req;
  logic [31:0] call_addr;
  logic        ret_req;
  logic        err_clear;
  logic        busy;
  logic        call_done;
  logic        ret_valid;
  logic [31:0] ret_addr;
  logic [4:0]  depth;
  logic        overflow_err;
  logic        underflow_err;
  logic        stk_push;
  logic        stk_pop;
  logic [31:0] stk_data_in;
  logic [31:0] stk_data_out;
  logic        stk_full;
  logic        stk_empty;

  int errors = 0;
  int checks = 0;

  // Stack model: no reset, DataOut updates on the pop edge, full at pointer 31.
  logic [31:0] m_mem [32];
  logic [5:0]  m_ptr = 6'd0;
  logic        m_load;
  logic [5:0]  m_load_cnt;

  always @(posedge clock) begin
    if (m_load) begin
      m_ptr <= m_load_cnt;
    end else if (stk_push && m_ptr < 6'd32) begin
      m_mem[m_ptr[4:0]] <= stk_data_in;
      m_ptr             <= m_ptr + 6'd1;
    end else if (stk_pop && m_ptr > 6'd0) begin
      stk_data_out <= m_mem[5'(m_ptr - 6'd1)];
      m_ptr        <= m_ptr - 6'd1;
    end
  end

  assign stk_full  = (m_ptr == 6'd31);
  assign stk_empty = (m_ptr == 6'd0);

  call_stack_controller dut (
    .clock         (clock),
    .reset         (reset),
    .call_req      (call_req),
    .call_addr     (call_addr),
    .ret_req       (ret_req),
    .err_clear     (err_clear),
    .busy          (busy),
    .call_done     (call_done),
    .ret_valid     (ret_valid),
    .ret_addr      (ret_addr),
    .depth         (depth),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .stk_push      (stk_push),
    .stk_pop       (stk_pop),
    .stk_data_in   (stk_data_in),
    .stk_data_out  (stk_data_out),
    .stk_full      (stk_full),
    .stk_empty     (stk_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue a CALL that should be accepted; checks push timing and completion.
  task automatic do_call(input logic [31:0] addr, input logic [4:0] exp_depth);
    call_req  = 1'b1;
    call_addr = addr;
    step();
    call_req = 1'b0;
    check("call_push", 32'(stk_push), 32'd1);
    check("call_data_in", stk_data_in, addr);
    check("call_done_early", 32'(call_done), 32'd0);
    step();
    check("call_done", 32'(call_done), 32'd1);
    check("call_depth", 32'(depth), 32'(exp_depth));
    check("call_idle", 32'(busy), 32'd0);
  endtask

  // Issue a RET that should pop; ret_valid must appear exactly 3 cycles later.
  task automatic do_ret(input logic [31:0] exp_addr, input logic [4:0] exp_depth);
    ret_req = 1'b1;
    step();
    ret_req = 1'b0;
    check("ret_pop", 32'(stk_pop), 32'd1);
    check("ret_valid_n1", 32'(ret_valid), 32'd0);
    step();
    check("ret_capture_busy", 32'(busy), 32'd1);
    check("ret_valid_n2", 32'(ret_valid), 32'd0);
    step();
    check("ret_valid_n3", 32'(ret_valid), 32'd1);
    check("ret_addr", ret_addr, exp_addr);
    check("ret_depth", 32'(depth), 32'(exp_depth));
    step();
    check("ret_valid_pulse", 32'(ret_valid), 32'd0);
  endtask

  // Wait (bounded) for the drain to finish, counting pop cycles.
  task automatic drain(output int pops, output bit rv_seen, output bit timed_out);
    pops      = 0;
    rv_seen   = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (ret_valid) rv_seen = 1'b1;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      if (stk_pop) pops++;
      step();
    end
  endtask

  int pops;
  bit rv_seen;
  bit timed_out;

  initial begin
    reset      = 1'b1;
    call_req   = 1'b0;
    call_addr  = '0;
    ret_req    = 1'b0;
    err_clear  = 1'b0;
    m_load     = 1'b1;
    m_load_cnt = 6'd3;
    step();
    m_load = 1'b0;
    step();

    // Reset state with a preloaded stack.
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_pop_gated", 32'(stk_pop), 32'd0);
    check("rst_call_done", 32'(call_done), 32'd0);
    check("rst_ret_valid", 32'(ret_valid), 32'd0);
    check("rst_ret_addr", ret_addr, 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_udf", 32'(underflow_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    reset = 1'b0;
    #1;
    check("drain_pop_first", 32'(stk_pop), 32'd1);
    drain(pops, rv_seen, timed_out);
    check("drain1_timeout", 32'(timed_out), 32'd0);
    check("drain1_pops", 32'(pops), 32'd3);
    check("drain1_depth", 32'(depth), 32'd0);
    check("drain1_strobes", 32'({stk_push, stk_pop}), 32'd0);

    // Nested CALL/RET.
    do_call(32'h0000_1000, 5'd1);
    do_call(32'h0000_2000, 5'd2);
    do_ret(32'h0000_2000, 5'd1);
    do_ret(32'h0000_1000, 5'd0);

    // RET on empty: no pop, error, zeroed result next cycle.
    ret_req = 1'b1;
    step();
    ret_req = 1'b0;
    check("udf_no_pop", 32'(stk_pop), 32'd0);
    check("udf_flag", 32'(underflow_err), 32'd1);
    check("udf_ret_valid", 32'(ret_valid), 32'd1);
    check("udf_ret_addr", ret_addr, 32'd0);
    check("udf_busy", 32'(busy), 32'd0);
    step();
    check("udf_pulse", 32'(ret_valid), 32'd0);
    check("udf_sticky", 32'(underflow_err), 32'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("udf_clear", 32'(underflow_err), 32'd0);

    // Fill to 31, then one CALL too many.
    for (int i = 1; i <= 31; i++) begin
      do_call(32'h0001_0000 + 32'(i), 5'(i));
    end
    check("full_stack", 32'(stk_full), 32'd1);
    call_req  = 1'b1;
    call_addr = 32'hDEAD_BEEF;
    step();
    call_req = 1'b0;
    check("ovf_no_push", 32'(stk_push), 32'd0);
    check("ovf_flag", 32'(overflow_err), 32'd1);
    check("ovf_call_done", 32'(call_done), 32'd1);
    check("ovf_depth", 32'(depth), 32'd31);
    step();
    check("ovf_pulse", 32'(call_done), 32'd0);
    check("ovf_sticky", 32'(overflow_err), 32'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("ovf_clear", 32'(overflow_err), 32'd0);

    // Reset with a full stack drains all 31 entries.
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    drain(pops, rv_seen, timed_out);
    check("drain2_timeout", 32'(timed_out), 32'd0);
    check("drain2_pops", 32'(pops), 32'd31);
    check("drain2_empty", 32'(stk_empty), 32'd1);

    // CALL and RET together at depth 2: CALL wins; RET while busy is ignored.
    do_call(32'h0000_A000, 5'd1);
    do_call(32'h0000_B000, 5'd2);
    call_req  = 1'b1;
    ret_req   = 1'b1;
    call_addr = 32'h0000_C000;
    step();
    call_req = 1'b0;
    check("both_push", 32'(stk_push), 32'd1);
    check("both_no_pop", 32'(stk_pop), 32'd0);
    step();
    ret_req = 1'b0;
    check("both_depth", 32'(depth), 32'd3);
    check("both_call_done", 32'(call_done), 32'd1);
    step();
    check("busy_ret_ignored_pop", 32'(stk_pop), 32'd0);
    check("busy_ret_ignored_busy", 32'(busy), 32'd0);
    check("busy_ret_ignored_depth", 32'(depth), 32'd3);

    // Reset during POP aborts it immediately and drains the remaining entries.
    ret_req = 1'b1;
    step();
    ret_req = 1'b0;
    check("abort_pop_before", 32'(stk_pop), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_pop_dropped", 32'(stk_pop), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("abort_depth", 32'(depth), 32'd0);
    drain(pops, rv_seen, timed_out);
    check("drain3_timeout", 32'(timed_out), 32'd0);
    check("drain3_pops", 32'(pops), 32'd3);
    check("abort_no_ret_valid", 32'(rv_seen), 32'd0);
    check("drain3_empty", 32'(stk_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
